// File: rtl/mmm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmm_pkg                                                          |
// | Brief    : Shared types and defaults for the Montgomery multiplier slice.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package mmm_pkg;

  localparam int MMM_DEFAULT_WIDTH = 8;
  localparam int MMM_DEFAULT_DIGIT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REDUCE = 2'd2,
    HOLD   = 2'd3
  } mmm_res_state_e;

endpackage
`default_nettype wire

// File: rtl/mmm_cond_sub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmm_cond_sub                                                     |
// | Brief    : Final conditional subtraction of the modulus from the accumulator|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmm_cond_sub
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mod_i,
  output logic [WIDTH-1:0] res_o
);

  logic w_ge;

  // acc < 2N is guaranteed upstream, so the low WIDTH bits of the difference suffice
  always_comb begin
    w_ge  = (acc_i >= {1'b0, mod_i});
    res_o = w_ge ? (acc_i[WIDTH-1:0] - mod_i) : acc_i[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mmm_res_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmm_res_reg                                                      |
// | Brief    : MMM partial-result register, iteration counter, final reduction. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmm_res_reg
  import mmm_pkg::*;
#(
  parameter  int WIDTH = MMM_DEFAULT_WIDTH,
  parameter  int DIGIT = MMM_DEFAULT_DIGIT,
  localparam int ITER  = WIDTH / DIGIT,
  localparam int CW    = $clog2(ITER + 1)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   clr_i,
  input  logic                   start_i,
  input  logic                   en_i,
  input  logic [WIDTH+DIGIT:0]   rjo_i,
  input  logic [WIDTH-1:0]       mod_i,
  output logic [WIDTH:0]         reg_rji_o,
  output logic [CW-1:0]          iter_o,
  output logic                   busy_o,
  output logic [WIDTH-1:0]       res_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic                   lsb_err_o
);

  localparam logic [CW-1:0] c_last_iter = CW'(ITER - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_param_check
      $error("mmm_res_reg: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  mmm_res_state_e   r_state, w_state_nxt;
  logic [WIDTH:0]   r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_res, w_res_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] w_sub_res;

  mmm_cond_sub #(
    .WIDTH (WIDTH)
  ) u_cond_sub (
    .acc_i (r_acc),
    .mod_i (mod_i),
    .res_o (w_sub_res)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    if (clr_i) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_res_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            w_state_nxt = RUN;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b0;
          end
        end
        RUN: begin
          if (start_i) begin
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
            w_err_nxt = 1'b0;
          end else if (en_i) begin
            // Low DIGIT bits are zero by construction; dropping them is the radix shift
            w_acc_nxt = rjo_i[WIDTH+DIGIT:DIGIT];
            w_cnt_nxt = r_cnt + 1'b1;
            if (|rjo_i[DIGIT-1:0]) w_err_nxt = 1'b1;
            if (r_cnt == c_last_iter) w_state_nxt = REDUCE;
          end
        end
        REDUCE: begin
          w_res_nxt   = w_sub_res;
          w_valid_nxt = 1'b1;
          w_state_nxt = HOLD;
        end
        HOLD: begin
          if (r_valid && res_ready_i) begin
            w_valid_nxt = 1'b0;
            if (start_i) begin
              w_state_nxt = RUN;
              w_acc_nxt   = '0;
              w_cnt_nxt   = '0;
              w_err_nxt   = 1'b0;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == REDUCE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign reg_rji_o   = r_acc;
  assign iter_o      = r_cnt;
  assign busy_o      = r_busy;
  assign res_o       = r_res;
  assign res_valid_o = r_valid;
  assign lsb_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mmm_res_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mmm_res_reg                                                   |
// | Brief    : Self-checking bench for mmm_res_reg, DIGIT=1 and DIGIT=2 builds. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mmm_res_reg;

  logic clk = 1'b0;
  logic rstb, clr;
  always #5 clk = ~clk;

  // DIGIT = 1 instance
  logic       start1, en1, ready1, busy1, valid1, err1;
  logic [9:0] rjo1;
  logic [7:0] mod1, res1;
  logic [8:0] rji1;
  logic [3:0] iter1;

  // DIGIT = 2 instance
  logic        start2, en2, ready2, busy2, valid2, err2;
  logic [10:0] rjo2;
  logic [7:0]  mod2, res2;
  logic [8:0]  rji2;
  logic [2:0]  iter2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mmm_res_reg #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rstb(rstb), .clr_i(clr), .start_i(start1), .en_i(en1),
    .rjo_i(rjo1), .mod_i(mod1), .reg_rji_o(rji1), .iter_o(iter1),
    .busy_o(busy1), .res_o(res1), .res_valid_o(valid1),
    .res_ready_i(ready1), .lsb_err_o(err1)
  );

  mmm_res_reg #(.WIDTH(8), .DIGIT(2)) dut2 (
    .clk(clk), .rstb(rstb), .clr_i(clr), .start_i(start2), .en_i(en2),
    .rjo_i(rjo2), .mod_i(mod2), .reg_rji_o(rji2), .iter_o(iter2),
    .busy_o(busy2), .res_o(res2), .res_valid_o(valid2),
    .res_ready_i(ready2), .lsb_err_o(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start1_pulse();
    start1 = 1'b1; step(); start1 = 1'b0;
  endtask

  task automatic en1_step(input logic [9:0] v);
    en1 = 1'b1; rjo1 = v; step(); en1 = 1'b0;
  endtask

  task automatic start2_pulse();
    start2 = 1'b1; step(); start2 = 1'b0;
  endtask

  task automatic en2_step(input logic [10:0] v);
    en2 = 1'b1; rjo2 = v; step(); en2 = 1'b0;
  endtask

  // Start plus 8 steps; only the last datapath value matters for the final acc
  task automatic run8(input logic [9:0] first, input logic [9:0] last);
    start1_pulse();
    en1_step(first);
    for (int i = 0; i < 6; i++) en1_step(10'($urandom) & 10'h3FE);
    en1_step(last);
  endtask

  // Datapath model: pick q so the sum is divisible by 2^digit
  function automatic longint dp_sum(longint r, longint aj, longint b, longint n, int digit);
    longint t = r + aj * b;
    for (int q = 0; q < (1 << digit); q++)
      if (((t + q * n) % (1 << digit)) == 0) return t + q * n;
    return t;
  endfunction

  // Montgomery product a*b*2^-w mod n, found by direct search
  function automatic longint mont_ref(longint a, longint b, longint n, int w);
    for (longint x = 0; x < n; x++)
      if (((x << w) % n) == ((a * b) % n)) return x;
    return 0;
  endfunction

  task automatic test_reset();
    chk_cnt++; if ({rji1, iter1, busy1, valid1, res1, err1} !== '0) $display("FAIL reset_state: got %h want 0", {rji1, iter1, busy1, valid1, res1, err1}); else pass_cnt++;
    chk_cnt++; if ({rji2, iter2, busy2, valid2, res2, err2} !== '0) $display("FAIL reset_state2: got %h want 0", {rji2, iter2, busy2, valid2, res2, err2}); else pass_cnt++;
    rstb = 1'b1; step();
    start1_pulse();
    for (int i = 0; i < 3; i++) en1_step(10'h1F6);
    chk_cnt++; if (iter1 !== 4'd3) $display("FAIL pre_reset_iter: got %0d want 3", iter1); else pass_cnt++;
    rstb = 1'b0; #2;
    chk_cnt++; if ({rji1, iter1, busy1} !== '0) $display("FAIL async_reset: got %h want 0", {rji1, iter1, busy1}); else pass_cnt++;
    @(posedge clk); #1 rstb = 1'b1;
    start1_pulse();
    for (int i = 0; i < 3; i++) en1_step(10'h1F6);
    clr = 1'b1; #2;
    chk_cnt++; if (iter1 !== 4'd3) $display("FAIL clr_sync: got %0d want 3", iter1); else pass_cnt++;
    step(); clr = 1'b0;
    chk_cnt++; if ({rji1, iter1, busy1, valid1, err1} !== '0) $display("FAIL clr_state: got %h want 0", {rji1, iter1, busy1, valid1, err1}); else pass_cnt++;
  endtask

  task automatic test_shift();
    start1_pulse();
    en1_step(10'h1F6);
    chk_cnt++; if (rji1 !== 9'h0FB) $display("FAIL shift_acc: got %h want 0fb", rji1); else pass_cnt++;
    chk_cnt++; if (iter1 !== 4'd1) $display("FAIL shift_iter: got %0d want 1", iter1); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cnt++; if ({rji1, iter1, busy1} !== {9'h0FB, 4'd1, 1'b1}) $display("FAIL shift_hold: got %h want %h", {rji1, iter1, busy1}, {9'h0FB, 4'd1, 1'b1}); else pass_cnt++;
    end
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_full_run();
    logic [9:0] lasts [2] = '{10'h180, 10'h140};
    logic [7:0] exps  [2] = '{8'h0B, 8'hA0};
    mod1 = 8'hB5;
    for (int k = 0; k < 2; k++) begin
      run8(10'h002, lasts[k]);
      chk_cnt++; if ({valid1, busy1, iter1} !== {1'b0, 1'b1, 4'd8}) $display("FAIL reduce_state: got %h want %h", {valid1, busy1, iter1}, {1'b0, 1'b1, 4'd8}); else pass_cnt++;
      chk_cnt++; if (rji1 !== 9'(lasts[k] >> 1)) $display("FAIL final_acc: got %h want %h", rji1, 9'(lasts[k] >> 1)); else pass_cnt++;
      step();
      chk_cnt++; if ({valid1, busy1} !== 2'b10) $display("FAIL valid_latency: got %b want 10", {valid1, busy1}); else pass_cnt++;
      chk_cnt++; if (res1 !== exps[k]) $display("FAIL reduce_res: got %h want %h", res1, exps[k]); else pass_cnt++;
      ready1 = 1'b1; step(); ready1 = 1'b0;
      chk_cnt++; if ({valid1, busy1} !== 2'b00) $display("FAIL handshake_idle: got %b want 00", {valid1, busy1}); else pass_cnt++;
    end
  endtask

  task automatic test_handshake();
    mod1 = 8'hB5;
    run8(10'h004, 10'h180);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk_cnt++; if ({valid1, res1} !== {1'b1, 8'h0B}) $display("FAIL hold_stable: got %h want 10b", {valid1, res1}); else pass_cnt++;
    end
    start1_pulse();
    chk_cnt++; if ({valid1, busy1, iter1} !== {1'b1, 1'b0, 4'd8}) $display("FAIL start_in_hold: got %h want %h", {valid1, busy1, iter1}, {1'b1, 1'b0, 4'd8}); else pass_cnt++;
    start1 = 1'b1; ready1 = 1'b1; step(); start1 = 1'b0; ready1 = 1'b0;
    chk_cnt++; if ({valid1, busy1, iter1, rji1} !== {1'b0, 1'b1, 4'd0, 9'd0}) $display("FAIL start_with_ready: got %h want %h", {valid1, busy1, iter1, rji1}, {1'b0, 1'b1, 4'd0, 9'd0}); else pass_cnt++;
    clr = 1'b1; step(); clr = 1'b0;
    run8(10'h004, 10'h180);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    chk_cnt++; if ({valid1, res1, busy1} !== '0) $display("FAIL clr_in_hold: got %h want 0", {valid1, res1, busy1}); else pass_cnt++;
  endtask

  task automatic test_lsb_err();
    mod1 = 8'hB5;
    run8(10'h001, 10'h180);
    chk_cnt++; if (err1 !== 1'b1) $display("FAIL err_set: got %b want 1", err1); else pass_cnt++;
    step();
    chk_cnt++; if ({err1, valid1} !== 2'b11) $display("FAIL err_sticky_hold: got %b want 11", {err1, valid1}); else pass_cnt++;
    ready1 = 1'b1; step(); ready1 = 1'b0;
    chk_cnt++; if (err1 !== 1'b1) $display("FAIL err_sticky_idle: got %b want 1", err1); else pass_cnt++;
    start1_pulse();
    chk_cnt++; if (err1 !== 1'b0) $display("FAIL err_cleared: got %b want 0", err1); else pass_cnt++;
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_digit2();
    mod2 = 8'hB5;
    start2_pulse();
    en2_step(11'h3F4);
    chk_cnt++; if ({rji2, iter2} !== {9'h0FD, 3'd1}) $display("FAIL d2_shift: got %h want %h", {rji2, iter2}, {9'h0FD, 3'd1}); else pass_cnt++;
    en2_step(11'h008);
    en2_step(11'h010);
    step();
    chk_cnt++; if ({busy2, valid2, iter2} !== {1'b1, 1'b0, 3'd3}) $display("FAIL d2_three_steps: got %h want %h", {busy2, valid2, iter2}, {1'b1, 1'b0, 3'd3}); else pass_cnt++;
    en2_step(11'h300);
    chk_cnt++; if ({busy2, valid2, iter2, rji2} !== {1'b1, 1'b0, 3'd4, 9'h0C0}) $display("FAIL d2_reduce: got %h want %h", {busy2, valid2, iter2, rji2}, {1'b1, 1'b0, 3'd4, 9'h0C0}); else pass_cnt++;
    step();
    chk_cnt++; if ({valid2, res2} !== {1'b1, 8'h0B}) $display("FAIL d2_result: got %h want 10b", {valid2, res2}); else pass_cnt++;
    ready2 = 1'b1; step(); ready2 = 1'b0;
    start2_pulse();
    en2_step(11'h3F4);
    en2_step(11'h3F4);
    start2_pulse();
    chk_cnt++; if ({busy2, iter2, rji2} !== {1'b1, 3'd0, 9'd0}) $display("FAIL d2_restart: got %h want %h", {busy2, iter2, rji2}, {1'b1, 3'd0, 9'd0}); else pass_cnt++;
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_random_d1(input int runs);
    longint n, a, b, r, s;
    for (int k = 0; k < runs; k++) begin
      n = longint'($urandom_range(1, 127)) * 2 + 1;
      a = longint'($urandom_range(0, 32'(n - 1)));
      b = longint'($urandom_range(0, 32'(n - 1)));
      mod1 = 8'(n); r = 0;
      start1_pulse();
      for (int j = 0; j < 8; j++) begin
        repeat ($urandom_range(0, 2)) step();
        s = dp_sum(r, (a >> j) & 1, b, n, 1);
        en1_step(10'(s));
        r = s >> 1;
        chk_cnt++; if ({rji1, iter1} !== {9'(r), 4'(j + 1)}) $display("FAIL rnd1_step: got %h want %h", {rji1, iter1}, {9'(r), 4'(j + 1)}); else pass_cnt++;
      end
      step();
      chk_cnt++; if ({valid1, res1} !== {1'b1, 8'(mont_ref(a, b, n, 8))}) $display("FAIL rnd1_result: got %h want %h", {valid1, res1}, {1'b1, 8'(mont_ref(a, b, n, 8))}); else pass_cnt++;
      repeat ($urandom_range(0, 3)) step();
      ready1 = 1'b1; step(); ready1 = 1'b0;
    end
  endtask

  task automatic test_random_d2(input int runs);
    longint n, a, b, r, s;
    for (int k = 0; k < runs; k++) begin
      n = longint'($urandom_range(1, 127)) * 2 + 1;
      a = longint'($urandom_range(0, 32'(n - 1)));
      b = longint'($urandom_range(0, 32'(n - 1)));
      mod2 = 8'(n); r = 0;
      start2_pulse();
      for (int j = 0; j < 4; j++) begin
        repeat ($urandom_range(0, 2)) step();
        s = dp_sum(r, (a >> (2 * j)) & 3, b, n, 2);
        en2_step(11'(s));
        r = s >> 2;
        chk_cnt++; if ({rji2, iter2} !== {9'(r), 3'(j + 1)}) $display("FAIL rnd2_step: got %h want %h", {rji2, iter2}, {9'(r), 3'(j + 1)}); else pass_cnt++;
      end
      step();
      chk_cnt++; if ({valid2, res2, err2} !== {1'b1, 8'(mont_ref(a, b, n, 8)), 1'b0}) $display("FAIL rnd2_result: got %h want %h", {valid2, res2, err2}, {1'b1, 8'(mont_ref(a, b, n, 8)), 1'b0}); else pass_cnt++;
      ready2 = 1'b1; step(); ready2 = 1'b0;
    end
  endtask

  initial begin
    rstb = 1'b0; clr = 1'b0;
    start1 = 1'b0; en1 = 1'b0; rjo1 = '0; mod1 = '0; ready1 = 1'b0;
    start2 = 1'b0; en2 = 1'b0; rjo2 = '0; mod2 = '0; ready2 = 1'b0;
    step(); step();
    test_reset();
    test_shift();
    test_full_run();
    test_handshake();
    test_lsb_err();
    test_digit2();
    test_random_d1(20);
    test_random_d2(15);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mmm_res_reg.md
Name: mmm_res_reg

Overview:
Parametrised partial-result register for the radix-2^DIGIT Montgomery modular multiplier (MMM).
- Holds the running accumulator r and returns it to the datapath as (rjo >> DIGIT) on each iteration.
- Counts the WIDTH/DIGIT iterations itself, performs the final conditional subtraction of the modulus, and presents the result on a valid/ready handshake.
- Sits between the MMM adder datapath and the RSA exponentiation controller.

Parameters:
- WIDTH, 8, operand and modulus width in bits.
- DIGIT, 1, bits retired per iteration (radix 2^DIGIT). WIDTH % DIGIT == 0 is required, checked by elaboration assertion.
- ITER (localparam), WIDTH/DIGIT, iterations per multiplication.
- CW (localparam), $clog2(ITER+1), iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous soft clear, highest priority after rstb.
- start_i  in  1  begin a multiplication: zero the accumulator and counter.
- en_i  in  1  iteration step strobe from the datapath.
- rjo_i  in  WIDTH+DIGIT+1  datapath sum r + a_j*B + q_j*N. Low DIGIT bits are zero by construction.
- mod_i  in  WIDTH  modulus N. Stable from start_i until the handshake completes.
- reg_rji_o  out  WIDTH+1  registered accumulator, fed back to the datapath.
- iter_o  out  CW  completed iteration count.
- busy_o  out  1  high in RUN and REDUCE.
- res_o  out  WIDTH  reduced result.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer ready.
- lsb_err_o  out  1  sticky: an enabled step had non-zero rjo_i[DIGIT-1:0].

Behaviour:
Reset (rstb low, async):
- State = IDLE.
- acc, cnt, res_o, res_valid_o, busy_o and lsb_err_o all 0.

clr_i (synchronous):
- Same values as reset, applied on the next edge.
- Overrides every other input in every state, including mid-RUN and mid-HOLD.

IDLE:
- start_i: acc <= 0, cnt <= 0, lsb_err_o <= 0, go to RUN.
- en_i is ignored.

RUN:
- start_i (priority over en_i): restart with acc <= 0, cnt <= 0, lsb_err_o <= 0.
- Else en_i: acc <= rjo_i >> DIGIT (truncated to WIDTH+1 bits), cnt <= cnt+1.
- Also on en_i: lsb_err_o is set if rjo_i[DIGIT-1:0] != 0.
- en_i with cnt == ITER-1 goes to REDUCE.
- en_i low holds all state.

REDUCE (exactly 1 cycle, en_i/start_i ignored):
- If acc >= {1'b0, mod_i}: res_o <= (acc - mod_i)[WIDTH-1:0].
- Else: res_o <= acc[WIDTH-1:0].
- res_valid_o <= 1, go to HOLD.
- Only one subtraction is performed; acc < 2N is an algorithm precondition and is not checked.

HOLD:
- res_o and res_valid_o are stable until res_ready_i.
- res_valid_o && res_ready_i: res_valid_o <= 0, go to IDLE.
- If start_i is high in the same cycle as the handshake: go straight to RUN with acc and cnt zeroed.
- start_i without res_ready_i is ignored.

Outputs and timing:
- reg_rji_o = acc at all times.
- acc is retained through REDUCE/HOLD until the next start or clear.
- iter_o = cnt.
- busy_o = (state == RUN || state == REDUCE).
- Latency: start_i edge at cycle 0 → RUN from cycle 1. After the ITER-th en_i → REDUCE next cycle → res_valid_o high one cycle later.
- Minimum total latency: ITER+2 cycles after start_i.
- All outputs are registered.

Decomposition:
- Package mmm_pkg:
  - mmm_res_state_e enum {IDLE, RUN, REDUCE, HOLD}.
  - MMM_DEFAULT_WIDTH and MMM_DEFAULT_DIGIT constants.
- Sub-module mmm_cond_sub (combinational, WIDTH param): compare and subtract of acc against mod_i, returning the WIDTH-bit result.
- FSM, counter and accumulator stay in mmm_res_reg.

Test Plan:
- Reset/clear: assert rstb low mid-RUN at cnt=3 → all outputs 0 immediately, state IDLE. Repeat with clr_i → same values on the next edge.
- Shift update (WIDTH=8, DIGIT=1): start, then en_i with rjo_i=10'h1F6 → reg_rji_o=9'h0FB, iter_o=1. Next, en_i low 3 cycles → values hold.
- Full run plus reduction: 8 en_i steps, last rjo_i=10'h180, mod_i=8'hB5 → acc=9'h0C0, res_o=8'h0B, valid 2 cycles after the last en_i. Same run ending at acc=9'h0A0 → res_o=8'hA0.
- Handshake: res_ready_i low 5 cycles → res_valid_o and res_o stable. start_i alone in HOLD is ignored. start_i together with res_ready_i → RUN next cycle, iter_o=0, reg_rji_o=0.
- Error flag: en_i with rjo_i=10'h001 → lsb_err_o=1, stays 1 through completion, cleared by the next start_i.
- DIGIT=2 configuration (WIDTH=8, ITER=4): rjo_i=11'h3F4 → reg_rji_o=9'h0FD. REDUCE entered after exactly 4 en_i. start_i mid-RUN at cnt=2 → cnt=0, acc=0.
